// File: rtl/fxp_to_fp32_converter.sv
// fxp_to_fp32_converter
//
// Converts a sign-magnitude fixed-point number into an IEEE-754 single
// precision word. The magnitude is normalised one bit per cycle, and then
// packed, with optional round-to-nearest-even when more than 23 fraction
// bits survive normalisation.
//
// Parameters
//   IN_WIDTH   : magnitude width, 2..32
//   ROUND_MODE : 0 = truncate toward zero, 1 = round-to-nearest-even
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : input word present
//   in_ready   : block can accept (only while idle)
//   in_mag     : unsigned magnitude
//   in_point   : number of fractional bits in in_mag
//   in_sign    : 1 = negative
//   out_valid  : out_data holds a result
//   out_ready  : consumer accepts the result
//   out_data   : {sign, exp[7:0], frac[22:0]}
module fxp_to_fp32_converter #(
  parameter int IN_WIDTH   = 16,
  parameter int ROUND_MODE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_WIDTH-1:0]         in_mag,
  input  logic [$clog2(IN_WIDTH)-1:0] in_point,
  input  logic                        in_sign,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_data
);

  // Number of magnitude bits that sit below the leading one after normalisation.
  localparam int FW = IN_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IN_WIDTH-1:0] mag_q;
  logic                sign_q;
  logic [7:0]          exp_q;

  logic [7:0]          exp_init;
  logic                mag_zero;
  logic                mag_msb;
  logic [FW+23:0]      ext;
  logic [22:0]         frac_t;
  logic                guard;
  logic                sticky;
  logic                round_up;
  logic [23:0]         frac_sum;
  logic [7:0]          exp_pack;

  // Biased exponent of the leading magnitude bit before any normalising shift.
  assign exp_init = 8'(127 + FW) - 8'(in_point);

  assign mag_zero = (mag_q == '0);
  assign mag_msb  = mag_q[IN_WIDTH-1];

  // The bits below the leading one are padded with 24 zeros so the same
  // slicing works for every width: the top 23 bits are the fraction, the next
  // bit is the guard and everything below is the sticky field. When fewer
  // than 24 magnitude bits exist, guard and sticky fall into the zero padding
  // and rounding naturally never fires.
  assign ext      = {mag_q[FW-1:0], 24'b0};
  assign frac_t   = ext[FW+23 -: 23];
  assign guard    = ext[FW];
  assign sticky   = |ext[FW-1:0];
  assign round_up = (ROUND_MODE == 1) && guard && (sticky || frac_t[0]);
  assign frac_sum = {1'b0, frac_t} + {23'b0, round_up};

  // A carry out of the fraction leaves frac_sum[22:0] at zero, so only the
  // exponent needs adjusting.
  assign exp_pack = frac_sum[23] ? exp_q + 8'd1 : exp_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and handshake outputs. Normalisation stops on a set
  // MSB or on a zero magnitude, so a nonzero word needs at most IN_WIDTH-1
  // shifts and an illegal in_point can only affect the exponent value.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE: if (in_valid) state_nxt = NORM;
      NORM: begin
        if (mag_zero) begin
          state_nxt = DONE;
        end else if (mag_msb) begin
          state_nxt = PACK;
        end
      end
      PACK: state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift while normalising, pack the result.
  // out_data is only written on the way into DONE, so it stays put while
  // the consumer applies backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q    <= '0;
      sign_q   <= 1'b0;
      exp_q    <= 8'd0;
      out_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_q  <= in_mag;
            sign_q <= in_sign;
            exp_q  <= exp_init;
          end
        end
        NORM: begin
          if (mag_zero) begin
            out_data <= {sign_q, 31'b0};
          end else if (!mag_msb) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 8'd1;
          end
        end
        PACK: out_data <= {sign_q, exp_pack, frac_sum[22:0]};
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fxp_to_fp32_converter.md
FXP_TO_FP32_CONVERTER -- requirements
Module: fxp_to_fp32_converter

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 16, legal range 2..32: unsigned magnitude width.
REQ-002 The block SHALL have parameter ROUND_MODE, default 1: 0 = truncate toward zero, 1 = round-to-nearest-even (RNE).
REQ-003 The block SHALL have one clock, clk, input, 1 bit: all state updates on its rising edge.
REQ-004 The block SHALL have reset rst_n, input, 1 bit: asynchronous, active-low.
REQ-005 The block SHALL have in_valid, input, 1 bit: input word present.
REQ-006 The block SHALL have in_ready, output, 1 bit: block can accept.
REQ-007 The block SHALL have in_mag, input, IN_WIDTH bits: unsigned magnitude.
REQ-008 The block SHALL have in_point, input, clog2(IN_WIDTH) bits: count of fractional bits, legal 0..IN_WIDTH-1.
REQ-009 The block SHALL have in_sign, input, 1 bit: 1 = negative.
REQ-010 The block SHALL have out_valid, output, 1 bit: out_data holds a result.
REQ-011 The block SHALL have out_ready, input, 1 bit: consumer accepts.
REQ-012 The block SHALL have out_data, output, 32 bits: IEEE-754 single {sign, exp[7:0], frac[22:0]}.

Function
REQ-013 The FSM SHALL use states IDLE, NORM, PACK and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 When IDLE and in_valid=1 at an edge, the block SHALL capture in_mag, in_sign and exp = 127 + (IN_WIDTH-1) - in_point, then enter NORM.
REQ-015 In NORM, if the captured magnitude is zero, the block SHALL load out_data = {sign, 31'b0} and enter DONE.
REQ-016 In NORM, if magnitude MSB = 1, the block SHALL enter PACK; otherwise it SHALL shift the magnitude left by 1 and decrement exp by 1, one shift per cycle.
REQ-017 In PACK, the block SHALL form frac from the bits below the MSB, left-aligned into 23 bits and zero-padded when IN_WIDTH-1 < 23.
REQ-018 When IN_WIDTH-1 > 23 and ROUND_MODE=1, the block SHALL apply RNE: guard = first dropped bit, sticky = OR of the remaining dropped bits, increment if guard & (sticky | frac LSB).
REQ-019 When IN_WIDTH-1 > 23 and ROUND_MODE=0, the block SHALL discard the dropped bits.
REQ-020 If rounding carries out of frac, the block SHALL set frac to 0 and exp to exp+1.
REQ-021 Exp arithmetic SHALL be at least 8 bits wide; with the legal parameter range, results SHALL be normal numbers and no overflow, denormal, Inf or NaN case SHALL exist.
REQ-022 PACK SHALL register out_data and enter DONE; out_valid SHALL equal (state == DONE).
REQ-023 In DONE, out_data SHALL remain stable until out_ready=1; at that edge the block SHALL return to IDLE.
REQ-024 An accepted input SHALL NOT be accepted again in the same transaction.
REQ-025 Latency from the accept edge to out_valid SHALL be 2 + lz edges, where lz = leading zeros of in_mag; for zero input it SHALL be 1 edge.
REQ-026 Changes on in_mag, in_point or in_sign outside IDLE SHALL have no effect.
REQ-027 An illegal in_point (>= IN_WIDTH) SHALL produce an undefined result but SHALL NOT hang the FSM.

Reset
REQ-028 While rst_n=0, the block SHALL hold state = IDLE, out_valid=0, out_data=0, and all internal registers at 0; in_ready SHALL be 1 after release.
REQ-029 Reset asserted in NORM, PACK or DONE SHALL abort the transaction immediately, with no output produced.
REQ-030 After reset release, the first edge with in_valid=1 SHALL be an accept.

Verification
REQ-031 IN_WIDTH=16, in_mag=0x0003, in_point=1, in_sign=0 -> out_data 0x3FC00000 (1.5), out_valid 16 edges after accept.
REQ-032 IN_WIDTH=16, in_mag=0x8000, in_point=0 -> 0x47000000, latency 2; with in_sign=1 -> 0xC7000000.
REQ-033 in_mag=0, in_sign=1 -> 0x80000000 after 1 edge; in_sign=0 -> 0x00000000.
REQ-034 IN_WIDTH=32, in_mag=0xFFFFFFFF, in_point=0: ROUND_MODE=1 -> 0x4F800000 (carry into exp); ROUND_MODE=0 -> 0x4F7FFFFF; RNE tie case 0x01000001, in_point=0 -> 0x4B800000 (round to even).
REQ-035 Backpressure test: out_ready=0 for 10 cycles in DONE -> out_data and out_valid stable, in_ready=0, and a new in_valid is ignored; out_ready=1 -> IDLE on the next edge, then the next input is accepted.
REQ-036 Reset test: rst_n pulsed low mid-NORM -> out_valid=0 and in_ready=1 immediately; no stale result appears afterwards.
